// File: rtl/arb_requester_if.sv
// Command, arbiter and beat-bus signals of one arbiter requester.
// The DUT takes the slave modport.
interface arb_requester_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LEN_W  = 4
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [LEN_W-1:0]  cmd_len;
    logic [DATA_W-1:0] cmd_data;
    logic              req;
    logic              gnt;
    logic              bus_valid;
    logic [DATA_W-1:0] bus_data;
    logic              bus_last;
    logic              done;
    logic [7:0]        stall_cnt;

    modport slave (
        input  cmd_valid, cmd_len, cmd_data, gnt,
        output cmd_ready, req, bus_valid, bus_data, bus_last, done, stall_cnt
    );

    modport master (
        output cmd_valid, cmd_len, cmd_data, gnt,
        input  cmd_ready, req, bus_valid, bus_data, bus_last, done, stall_cnt
    );
endinterface

// File: rtl/arb_requester.sv
// Requester agent: queues burst commands, requests the arbiter and streams
// base+idx beats while granted, holding position across grant withdrawal.
module arb_requester #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned LEN_W      = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic           clock,
    input  logic           reset_n,
    arb_requester_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_ARB, S_XFER, S_GAP} state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_mem_q  [FIFO_DEPTH];
    logic [DATA_W-1:0]  data_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               cmd_ready_q;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]  base_q, base_d;
    logic [7:0]         stall_q, stall_d;
    logic               req_q, done_q;
    logic               push, pop, beat, last_beat;

    assign push      = bus.cmd_valid && cmd_ready_q;
    assign pop       = (state_q == S_IDLE) && (count_q != '0);
    assign beat      = (state_q == S_XFER) && bus.gnt;
    assign last_beat = beat && (idx_q == len_q);
    assign count_d   = count_q + CNT_W'(push) - CNT_W'(pop);

    // Command storage needs no reset: occupancy alone defines validity.
    always_ff @(posedge clock) begin
        if (push) begin
            len_mem_q[wr_ptr_q]  <= bus.cmd_len;
            data_mem_q[wr_ptr_q] <= bus.cmd_data;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        base_d  = base_q;
        idx_d   = idx_q;
        stall_d = stall_q;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    state_d = S_ARB;
                    len_d   = len_mem_q[rd_ptr_q];
                    base_d  = data_mem_q[rd_ptr_q];
                    idx_d   = '0;
                end
            end
            S_ARB: begin
                if (bus.gnt) state_d = S_XFER;
            end
            S_XFER: begin
                if (bus.gnt) begin
                    if (idx_q == len_q) state_d = S_GAP;
                    else                idx_d   = idx_q + LEN_W'(1);
                end else if (stall_q != 8'hFF) begin
                    stall_d = stall_q + 8'd1;
                end
            end
            S_GAP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            cmd_ready_q <= 1'b1;
            len_q       <= '0;
            idx_q       <= '0;
            base_q      <= '0;
            stall_q     <= '0;
            req_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            cmd_ready_q <= (count_d != CNT_W'(FIFO_DEPTH));
            len_q       <= len_d;
            idx_q       <= idx_d;
            base_q      <= base_d;
            stall_q     <= stall_d;
            req_q       <= (state_d == S_ARB) || (state_d == S_XFER);
            done_q      <= (state_d == S_GAP);
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end

    // Beat signals follow gnt combinationally so a withdrawn grant costs no beat.
    assign bus.cmd_ready = cmd_ready_q;
    assign bus.req       = req_q;
    assign bus.done      = done_q;
    assign bus.stall_cnt = stall_q;
    assign bus.bus_valid = beat;
    assign bus.bus_last  = last_beat;
    assign bus.bus_data  = beat ? DATA_W'(base_q + DATA_W'(idx_q)) : '0;
endmodule
